// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Bundles the serial-line inputs, run/timebase controls and the parallel
//   receive results of uart_rx.
//
//   master : the receiver side (uart_rx). Consumes the line and controls,
//            produces the received byte, strobe and status.
//   slave  : the consumer side (pad driver / RX buffer / bench). Drives the
//            line and controls, observes the results.
//
//   Signals
//     rx_en          1 = receiver runs, 0 = receiver frozen
//     baud_divisor   bit period = baud_divisor+1 clk cycles (>= 3)
//     rx             asynchronous serial line, idle high
//     rx_dr          received payload, first bit in [7]
//     rx_done        one-cycle end-of-frame strobe
//     rx_parity_err  parity mismatch on the last frame
//     rx_frame_err   first stop bit sampled low on the last frame
//     rx_busy        receiver is inside a frame
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic        rx_en;
    logic [24:0] baud_divisor;
    logic        rx;
    logic [7:0]  rx_dr;
    logic        rx_done;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        rx_busy;

    modport master (
        input  rx_en,
        input  baud_divisor,
        input  rx,
        output rx_dr,
        output rx_done,
        output rx_parity_err,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx_en,
        output baud_divisor,
        output rx,
        input  rx_dr,
        input  rx_done,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial UART receiver, counterpart of uart_tx on the same baud_divisor
//   timebase. Deserialises MSB-first frames: start bit, payload, optional even
//   parity bit, stop bit. Produces a parallel byte with a one-cycle rx_done
//   strobe plus parity and framing error flags.
//
//   Parameters
//     DATA_BIT       frame bits after start, parity included (payload 1..8)
//     PARITY_BIT_EN  1 = last frame bit is even parity over the payload
//     STOP_BIT       0/1/2 = 1/1.5/2 stop bits; only the first is checked
//
//   Ports
//     clk    clock
//     reset  synchronous, active-low reset
//     bus    uart_rx_if.master: rx_en, baud_divisor, rx in;
//            rx_dr, rx_done, rx_parity_err, rx_frame_err, rx_busy out
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BIT      = 8,
    parameter int PARITY_BIT_EN = 0,
    parameter int STOP_BIT      = 0
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int PAYLOAD = DATA_BIT - PARITY_BIT_EN;
    localparam logic [3:0] LAST_DCNT = 4'(PAYLOAD - 1);

    // Reject configurations the datapath cannot represent.
    if (PAYLOAD < 1 || PAYLOAD > 8 || PARITY_BIT_EN > 1 || STOP_BIT > 2) begin : g_bad_params
        $error("uart_rx: unsupported DATA_BIT/PARITY_BIT_EN/STOP_BIT combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [24:0] bcnt_q, bcnt_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;          // running XOR of the payload bits
    logic        perr_q, perr_d;        // parity result of the frame in flight
    logic [7:0]  rx_dr_q, rx_dr_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_perr_q, rx_perr_d;
    logic        rx_ferr_q, rx_ferr_d;

    logic [24:0] half_div;
    logic        bit_end;
    logic [2:0]  bit_idx;

    assign half_div = bus.baud_divisor >> 1;
    assign bit_end  = (bcnt_q == bus.baud_divisor);
    assign bit_idx  = 3'd7 - dcnt_q[2:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            bcnt_q    <= '0;
            dcnt_q    <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            rx_dr_q   <= '0;
            rx_done_q <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else if (bus.rx_en) begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            dcnt_q    <= dcnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            rx_dr_q   <= rx_dr_d;
            rx_done_q <= rx_done_d;
            rx_perr_q <= rx_perr_d;
            rx_ferr_q <= rx_ferr_d;
        end else begin
            // The strobe is the only thing not frozen: it must never
            // stretch past one cycle while the receiver is paused.
            rx_done_q <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        dcnt_d    = dcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        perr_d    = perr_q;
        rx_dr_d   = rx_dr_q;
        rx_done_d = 1'b0;
        rx_perr_d = rx_perr_q;
        rx_ferr_d = rx_ferr_q;

        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                dcnt_d = '0;
                // Only a 1->0 transition starts a frame, so a held-low
                // line (break) waits here until it has gone high again.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (bcnt_q == half_div) begin
                    bcnt_d  = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    bcnt_d = bcnt_q + 25'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bcnt_d           = '0;
                    shift_d[bit_idx] = rx_s_q;
                    par_d            = par_q ^ rx_s_q;
                    dcnt_d           = dcnt_q + 4'd1;
                    if (dcnt_q == LAST_DCNT) begin
                        state_d = (PARITY_BIT_EN != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    bcnt_d = bcnt_q + 25'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    perr_d  = rx_s_q ^ par_q;
                    state_d = S_STOP;
                end else begin
                    bcnt_d = bcnt_q + 25'd1;
                end
            end
            S_STOP: begin
                // Return to IDLE at mid-stop so a start bit right after the
                // first stop bit is caught; extra stop time is plain idle.
                if (bit_end) begin
                    bcnt_d    = '0;
                    state_d   = S_IDLE;
                    rx_done_d = 1'b1;
                    rx_dr_d   = shift_q;
                    rx_ferr_d = ~rx_s_q;
                    rx_perr_d = perr_q;
                end else begin
                    bcnt_d = bcnt_q + 25'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rx_dr         = rx_dr_q;
    assign bus.rx_done       = rx_done_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx. Two receivers share one serial line:
//   u0 = 8 data bits, no parity; u1 = 7 data bits + even parity (8 frame bits),
//   so every frame driven on the line is a complete frame for both.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_line;
    logic        en_v;
    logic [24:0] div_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_if if0();
    uart_rx_if if1();

    assign if0.rx           = rx_line;
    assign if0.rx_en        = en_v;
    assign if0.baud_divisor = div_v;
    assign if1.rx           = rx_line;
    assign if1.rx_en        = en_v;
    assign if1.baud_divisor = div_v;

    uart_rx #(.DATA_BIT(8), .PARITY_BIT_EN(0), .STOP_BIT(0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.master)
    );

    uart_rx #(.DATA_BIT(8), .PARITY_BIT_EN(1), .STOP_BIT(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.master)
    );

    // Strobe monitor: counts pulses, records bytes, flags stretched pulses
    // and pulses while the receiver is paused.
    int         done0 = 0;
    int         done1 = 0;
    logic [7:0] q0[$];
    logic       pd0 = 1'b0;
    logic       pd1 = 1'b0;
    logic       wide = 1'b0;
    logic       done_while_off = 1'b0;

    always @(negedge clk) begin
        if (if0.rx_done === 1'b1) begin
            done0++;
            q0.push_back(if0.rx_dr);
            if (pd0) wide = 1'b1;
            if (!en_v) done_while_off = 1'b1;
        end
        if (if1.rx_done === 1'b1) begin
            done1++;
            if (pd1) wide = 1'b1;
        end
        pd0 = (if0.rx_done === 1'b1);
        pd1 = (if1.rx_done === 1'b1);
    end

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_line = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f, input logic stopv);
        int n;
        n = int'(div_v) + 1;
        send_bit(1'b0, n);
        for (int i = 7; i >= 0; i--) send_bit(f[i], n);
        send_bit(stopv, n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_line = 1'b1;
        en_v = 1'b1;
        div_v = 25'd9;
        repeat (3) @(negedge clk);
        checks++; if (if0.rx_dr !== 8'h00) begin errors++; $display("FAIL reset_rx_dr: got %h expected %h", if0.rx_dr, 8'h00); end
        checks++; if (if0.rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b expected 0", if0.rx_done); end
        checks++; if (if0.rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", if0.rx_parity_err); end
        checks++; if (if0.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", if0.rx_frame_err); end
        checks++; if (if0.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.rx_busy); end
        checks++; if (if1.rx_dr !== 8'h00) begin errors++; $display("FAIL reset_rx_dr_p: got %h expected %h", if1.rx_dr, 8'h00); end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int c0 = done0;
        int c1 = done1;
        send_frame(8'hA5, 1'b1);
        idle(5);
        checks++; if (done0 !== c0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d expected %0d", done0, c0 + 1); end
        checks++; if (if0.rx_dr !== 8'hA5) begin errors++; $display("FAIL basic_rx_dr: got %h expected %h", if0.rx_dr, 8'hA5); end
        checks++; if (if0.rx_frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", if0.rx_frame_err); end
        checks++; if (if0.rx_parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", if0.rx_parity_err); end
        checks++; if (if0.rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", if0.rx_busy); end
        checks++; if (done1 !== c1 + 1) begin errors++; $display("FAIL parity_ok_done_count: got %0d expected %0d", done1, c1 + 1); end
        checks++; if (if1.rx_dr !== 8'hA4) begin errors++; $display("FAIL parity_ok_rx_dr: got %h expected %h", if1.rx_dr, 8'hA4); end
        checks++; if (if1.rx_parity_err !== 1'b0) begin errors++; $display("FAIL parity_ok_perr: got %b expected 0", if1.rx_parity_err); end
    endtask

    task automatic test_parity();
        // Payload 1010010 (three ones) with parity bit 0 is a parity error.
        send_frame(8'hA4, 1'b1);
        idle(5);
        checks++; if (if1.rx_dr !== 8'hA4) begin errors++; $display("FAIL parity_bad_rx_dr: got %h expected %h", if1.rx_dr, 8'hA4); end
        checks++; if (if1.rx_parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_perr: got %b expected 1", if1.rx_parity_err); end
        checks++; if (if0.rx_dr !== 8'hA4) begin errors++; $display("FAIL noparity_rx_dr: got %h expected %h", if0.rx_dr, 8'hA4); end
        checks++; if (if0.rx_parity_err !== 1'b0) begin errors++; $display("FAIL noparity_perr: got %b expected 0", if0.rx_parity_err); end
    endtask

    task automatic test_glitch();
        int c0 = done0;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (if0.rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", if0.rx_busy); end
        idle(20);
        checks++; if (if0.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", if0.rx_busy); end
        checks++; if (done0 !== c0) begin errors++; $display("FAIL glitch_no_done: got %0d expected %0d", done0, c0); end
        checks++; if (if0.rx_dr !== 8'hA4) begin errors++; $display("FAIL glitch_rx_dr_hold: got %h expected %h", if0.rx_dr, 8'hA4); end
    endtask

    task automatic test_frame_err();
        int c0 = done0;
        send_frame(8'h3C, 1'b0);
        idle(15);
        checks++; if (done0 !== c0 + 1) begin errors++; $display("FAIL ferr_done_count: got %0d expected %0d", done0, c0 + 1); end
        checks++; if (if0.rx_dr !== 8'h3C) begin errors++; $display("FAIL ferr_rx_dr: got %h expected %h", if0.rx_dr, 8'h3C); end
        checks++; if (if0.rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", if0.rx_frame_err); end
        checks++; if (if0.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", if0.rx_busy); end
        send_frame(8'h5A, 1'b1);
        idle(5);
        checks++; if (done0 !== c0 + 2) begin errors++; $display("FAIL ferr_clear_done_count: got %0d expected %0d", done0, c0 + 2); end
        checks++; if (if0.rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear_flag: got %b expected 0", if0.rx_frame_err); end
        checks++; if (if0.rx_dr !== 8'h5A) begin errors++; $display("FAIL ferr_clear_rx_dr: got %h expected %h", if0.rx_dr, 8'h5A); end
    endtask

    task automatic test_reset_mid();
        int c0;
        send_bit(1'b0, 10);
        send_bit(1'b1, 10);
        send_bit(1'b0, 10);
        send_bit(1'b1, 3);
        checks++; if (if0.rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", if0.rx_busy); end
        rx_line = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (if0.rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", if0.rx_busy); end
        checks++; if (if0.rx_dr !== 8'h00) begin errors++; $display("FAIL rstmid_rx_dr: got %h expected %h", if0.rx_dr, 8'h00); end
        checks++; if (if1.rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_p: got %b expected 0", if1.rx_busy); end
        reset = 1'b1;
        idle(5);
        c0 = done0;
        send_frame(8'h81, 1'b1);
        idle(5);
        checks++; if (done0 !== c0 + 1) begin errors++; $display("FAIL rstmid_done_count: got %0d expected %0d", done0, c0 + 1); end
        checks++; if (if0.rx_dr !== 8'h81) begin errors++; $display("FAIL rstmid_rx_dr_after: got %h expected %h", if0.rx_dr, 8'h81); end
    endtask

    task automatic test_back_to_back();
        int         c0 = done0;
        int         sz = q0.size();
        logic [7:0] b2 = 8'hAA;
        send_frame(8'h55, 1'b1);
        // Second frame starts right after the first stop bit; bit 4 is
        // stretched by the 7-cycle pause since the receiver is frozen too.
        send_bit(1'b0, 10);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                rx_line = b2[i];
                repeat (2) @(negedge clk);
                en_v = 1'b0;
                repeat (7) @(negedge clk);
                checks++; if (if0.rx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_frozen: got %b expected 1", if0.rx_busy); end
                en_v = 1'b1;
                repeat (8) @(negedge clk);
            end else begin
                send_bit(b2[i], 10);
            end
        end
        send_bit(1'b1, 10);
        idle(5);
        checks++; if (done0 !== c0 + 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected %0d", done0, c0 + 2); end
        if (q0.size() >= sz + 2) begin
            checks++; if (q0[sz] !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h expected %h", q0[sz], 8'h55); end
            checks++; if (q0[sz + 1] !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h expected %h", q0[sz + 1], 8'hAA); end
        end
        checks++; if (if0.rx_frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b expected 0", if0.rx_frame_err); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got wide=%b expected 0", wide); end
        checks++; if (done_while_off !== 1'b0) begin errors++; $display("FAIL done_while_paused: got %b expected 0", done_while_off); end
    endtask

    task automatic test_loopback();
        logic [7:0] tx_bytes [5] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h6B};
        logic [6:0] pay;
        logic [7:0] frame;
        int c0;
        div_v = 25'd4;
        idle(5);
        c0 = done0;
        for (int k = 0; k < 5; k++) begin
            // Transmitter model: 8-bit frame for u0; for u1 the same frame
            // is a 7-bit payload followed by its even parity bit.
            pay = tx_bytes[k][6:0];
            frame = {pay, ^pay};
            send_frame(frame, 1'b1);
            idle(3);
            checks++; if (if0.rx_dr !== frame) begin errors++; $display("FAIL loop_rx_dr[%0d]: got %h expected %h", k, if0.rx_dr, frame); end
            checks++; if (if1.rx_dr !== {pay, 1'b0}) begin errors++; $display("FAIL loop_rx_dr_p[%0d]: got %h expected %h", k, if1.rx_dr, {pay, 1'b0}); end
            checks++; if (if1.rx_parity_err !== 1'b0) begin errors++; $display("FAIL loop_perr[%0d]: got %b expected 0", k, if1.rx_parity_err); end
        end
        checks++; if (done0 !== c0 + 5) begin errors++; $display("FAIL loop_done_count: got %0d expected %0d", done0, c0 + 5); end
    endtask

    initial begin
        reset = 1'b0;
        rx_line = 1'b1;
        en_v = 1'b1;
        div_v = 25'd9;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
